// File: rtl/atetris_input_cond.sv
// rtl/atetris_input_cond.sv - synchronise, debounce and coin-shape the Atari Tetris control inputs
module atetris_input_cond #(
    parameter int TICK_DIV   = 48000,
    parameter int DEB_TICKS  = 4,
    parameter int COIN_TICKS = 40,
    parameter int GAP_TICKS  = 60
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [10:0] RAW,
    output logic [10:0] INP,
    output logic        TICK
);

    localparam int TB_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TB_W-1:0] TB_MAX = TB_W'(TICK_DIV - 1);

    localparam int T_MAX = (COIN_TICKS > GAP_TICKS) ? COIN_TICKS : GAP_TICKS;
    localparam int T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [T_W-1:0] COIN_END = T_W'(COIN_TICKS - 1);
    localparam logic [T_W-1:0] GAP_END  = T_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_PULSE    = 2'd1,
        C_GAP      = 2'd2,
        C_WAIT_REL = 2'd3
    } coin_state_t;

    logic [TB_W-1:0] tb_cnt;
    logic [10:0]     sync1;
    logic [10:0]     sync2;
    logic [10:0]     db;
    logic [1:0]      db_coin;
    logic [1:0]      pulse;

    // Free-running timebase; TICK marks the last count of each period.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            tb_cnt <= '0;
        end else if (tb_cnt == TB_MAX) begin
            tb_cnt <= '0;
        end else begin
            tb_cnt <= tb_cnt + 1'b1;
        end
    end

    assign TICK = (tb_cnt == TB_MAX);

    // Two-flop synchroniser for the asynchronous control lines.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= RAW;
            sync2 <= sync1;
        end
    end

    generate
        if (DEB_TICKS == 0) begin : g_bypass
            assign db = sync2;
        end else begin : g_deb
            localparam int DC_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
            localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEB_TICKS - 1);

            logic [DC_W-1:0] dc [11];
            logic [10:0]     db_q;

            // A bit only changes after DEB_TICKS ticks of unbroken disagreement.
            always_ff @(posedge clk_sys or negedge RESET_N) begin
                if (!RESET_N) begin
                    db_q <= '0;
                    for (int i = 0; i < 11; i++) begin
                        dc[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < 11; i++) begin
                        if (sync2[i] == db_q[i]) begin
                            dc[i] <= '0;
                        end else if (TICK) begin
                            if (dc[i] == DC_MAX) begin
                                db_q[i] <= sync2[i];
                                dc[i]   <= '0;
                            end else begin
                                dc[i] <= dc[i] + 1'b1;
                            end
                        end
                    end
                end
            end

            assign db = db_q;
        end
    endgenerate

    assign db_coin = db[9:8];

    generate
        for (genvar c = 0; c < 2; c++) begin : g_coin
            coin_state_t    state;
            coin_state_t    state_nxt;
            logic [T_W-1:0] t;
            logic [T_W-1:0] t_nxt;
            logic           coin_pulse;

            // Coin shaper state and phase timer.
            always_ff @(posedge clk_sys or negedge RESET_N) begin
                if (!RESET_N) begin
                    state <= C_IDLE;
                    t     <= '0;
                end else begin
                    state <= state_nxt;
                    t     <= t_nxt;
                end
            end

            // One fixed pulse per insertion, a forced gap, then wait for release.
            always_comb begin
                state_nxt  = state;
                t_nxt      = t;
                coin_pulse = 1'b0;
                case (state)
                    C_IDLE: begin
                        if (db_coin[c]) begin
                            state_nxt = C_PULSE;
                            t_nxt     = '0;
                        end
                    end
                    C_PULSE: begin
                        coin_pulse = 1'b1;
                        if (TICK) begin
                            if (t == COIN_END) begin
                                state_nxt = C_GAP;
                                t_nxt     = '0;
                            end else begin
                                t_nxt = t + 1'b1;
                            end
                        end
                    end
                    C_GAP: begin
                        if (TICK) begin
                            if (t == GAP_END) begin
                                state_nxt = C_WAIT_REL;
                                t_nxt     = '0;
                            end else begin
                                t_nxt = t + 1'b1;
                            end
                        end
                    end
                    C_WAIT_REL: begin
                        if (!db_coin[c]) begin
                            state_nxt = C_IDLE;
                        end
                    end
                    default: begin
                        state_nxt = C_IDLE;
                        t_nxt     = '0;
                    end
                endcase
            end

            assign pulse[c] = coin_pulse;
        end
    endgenerate

    // Active-low output word, coin bits replaced by the shaped pulses.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            INP <= 11'h7FF;
        end else begin
            INP <= ~{db[10], pulse[1], pulse[0], db[7:0]};
        end
    end

endmodule

// File: tb/tb_atetris_input_cond.sv
// tb/tb_atetris_input_cond.sv - directed self-checking bench for atetris_input_cond
module tb_atetris_input_cond;

    logic        clk;
    logic        rst_n;
    logic [10:0] raw;
    logic [10:0] raw_b;
    logic [10:0] inp;
    logic [10:0] inp_b;
    logic        tick;
    logic        tick_b;

    int n_checks;
    int n_errors;

    int   run_len [2];
    int   win_cnt [2];
    logic conc_mode;
    logic conc_ok;

    atetris_input_cond #(
        .TICK_DIV  (4),
        .DEB_TICKS (2),
        .COIN_TICKS(3),
        .GAP_TICKS (2)
    ) u_dut (
        .clk_sys(clk),
        .RESET_N(rst_n),
        .RAW    (raw),
        .INP    (inp),
        .TICK   (tick)
    );

    atetris_input_cond #(
        .TICK_DIV  (4),
        .DEB_TICKS (0),
        .COIN_TICKS(3),
        .GAP_TICKS (2)
    ) u_byp (
        .clk_sys(clk),
        .RESET_N(rst_n),
        .RAW    (raw_b),
        .INP    (inp_b),
        .TICK   (tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        for (int b = 0; b < 2; b++) begin
            run_len[b] = 0;
            win_cnt[b] = 0;
        end
    endtask

    task automatic step_mon(input int n);
        for (int k = 0; k < n; k++) begin
            step(1);
            if (conc_mode && (inp[9] !== inp[8])) conc_ok = 1'b0;
            for (int b = 0; b < 2; b++) begin
                if (inp[8+b] == 1'b0) begin
                    run_len[b]++;
                end else if (run_len[b] > 0) begin
                    check("coin_width_11_to_13", 32'(run_len[b] >= 11 && run_len[b] <= 13), 32'd1);
                    win_cnt[b]++;
                    run_len[b] = 0;
                end
            end
        end
    endtask

    initial begin
        logic found;
        logic g_ok;

        n_checks  = 0;
        n_errors  = 0;
        conc_mode = 1'b0;
        conc_ok   = 1'b1;
        clr_mon();

        rst_n = 1'b0;
        raw   = 11'h7FF;
        raw_b = 11'h000;
        step(3);
        check("rst_inp", 32'(inp), 32'h7FF);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_inp_byp", 32'(inp_b), 32'h7FF);
        check("rst_tick_byp", 32'(tick_b), 32'd0);

        raw   = 11'h000;
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check("tick_phase", 32'(tick), 32'((i % 4) == 3));
        end
        check("idle_inp", 32'(inp), 32'h7FF);

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (tick) found = 1'b1;
            else step(1);
        end
        check("tick_found", 32'(found), 32'd1);
        raw[0] = 1'b1;
        step(9);
        check("deb_early", 32'(inp), 32'h7FF);
        step(1);
        check("deb_edge", 32'(inp), 32'h7FE);

        g_ok = 1'b1;
        for (int j = 0; j < 4; j++) begin
            raw[1] = 1'b1;
            step(1);
            raw[1] = 1'b0;
            if (inp !== 11'h7FE) g_ok = 1'b0;
            for (int k = 0; k < 5 + j; k++) begin
                step(1);
                if (inp !== 11'h7FE) g_ok = 1'b0;
            end
        end
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (inp !== 11'h7FE) g_ok = 1'b0;
        end
        check("glitch_rejected", 32'(g_ok), 32'd1);
        raw[0] = 1'b0;
        step(20);
        check("deb_release", 32'(inp), 32'h7FF);

        clr_mon();
        raw[8] = 1'b1;
        step_mon(200);
        raw[8] = 1'b0;
        step_mon(30);
        check("held_windows", 32'(win_cnt[0]), 32'd1);
        check("held_other_coin", 32'(win_cnt[1]), 32'd0);
        check("held_idle", 32'(inp), 32'h7FF);

        clr_mon();
        raw[8] = 1'b1;
        step_mon(40);
        raw[8] = 1'b0;
        step_mon(40);
        raw[8] = 1'b1;
        step_mon(40);
        raw[8] = 1'b0;
        step_mon(40);
        check("repeat_windows", 32'(win_cnt[0]), 32'd2);

        clr_mon();
        conc_mode = 1'b1;
        conc_ok   = 1'b1;
        raw[9:8]  = 2'b11;
        step_mon(100);
        raw[9:8]  = 2'b00;
        step_mon(30);
        conc_mode = 1'b0;
        check("conc_same_cycles", 32'(conc_ok), 32'd1);
        check("conc_windows_c1", 32'(win_cnt[0]), 32'd1);
        check("conc_windows_c2", 32'(win_cnt[1]), 32'd1);

        raw[8] = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (inp[8] == 1'b0) found = 1'b1;
        end
        check("mid_pulse_start", 32'(found), 32'd1);
        step(3);
        rst_n = 1'b0;
        #1;
        check("mid_pulse_reset", 32'(inp), 32'h7FF);
        step(3);
        check("mid_pulse_held_reset", 32'(inp), 32'h7FF);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(1);
            if (inp[8] == 1'b0) found = 1'b1;
        end
        check("mid_pulse_new_pulse", 32'(found), 32'd1);
        raw = 11'h000;
        step(40);
        check("final_idle", 32'(inp), 32'h7FF);

        check("byp_idle", 32'(inp_b), 32'h7FF);
        raw_b = 11'h055;
        step(2);
        check("byp_cycle2", 32'(inp_b), 32'h7FF);
        step(1);
        check("byp_cycle3", 32'(inp_b), 32'h7AA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
